// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, XLEN cycles per op.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle through a single '*' product.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(XLEN + 1);

   // Handshake: start is taken only when state is IDLE and flush is low; done is a one-cycle
   // pulse with result valid in that same cycle; busy stalls upstream for the whole CALC phase.

   state_t              state, state_nxt;
   logic [2*XLEN-1:0]   acc, acc_nxt;     // product, or {remainder, quotient}
   logic [XLEN-1:0]     md;               // multiplicand or divisor magnitude
   logic [2:0]          fq;
   logic                sa_q, sb_q;
   logic [CW-1:0]       cnt;

   logic                is_div, a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]     ma, mb;
   logic                div_zero, div_ovf, special, fast, accept;
   logic [XLEN-1:0]     special_res, fast_res, final_res;
   logic [XLEN:0]       sum, trial, diff;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quot, rem, mul_res, div_res;

   // Operand decode: only the signed flavours look at sign bits, so U ops never negate.
   always_comb begin
      is_div      = func3[2];
      a_signed    = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                    (func3 == 3'b100) || (func3 == 3'b110);
      b_signed    = (func3 == 3'b000) || (func3 == 3'b001) ||
                    (func3 == 3'b100) || (func3 == 3'b110);
      sa          = a_signed & op_a[XLEN-1];
      sb          = b_signed & op_b[XLEN-1];
      ma          = sa ? -op_a : op_a;
      mb          = sb ? -op_b : op_b;
      div_zero    = is_div && (op_b == '0);
      div_ovf     = is_div && !func3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = func3[1] ? op_a : '1;
      else if (div_ovf)
         special_res = func3[1] ? '0 : op_a;
      accept      = (state == IDLE) && start && !flush;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;

   always_comb begin
      ext_a     = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
      ext_b     = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
      fast_prod = ext_a * ext_b;
      fast_res  = (func3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
      fast      = !is_div;
   end
`else
   always_comb begin
      fast_res = '0;
      fast     = 1'b0;
   end
`endif

   // One iteration of the datapath plus the sign fix-up of its outcome, which is what gets
   // registered on the final CALC cycle so result is already valid while done is high.
   always_comb begin
      sum   = '0;
      trial = '0;
      diff  = '0;
      if (!fq[2]) begin
         sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md} : '0);
         acc_nxt = {sum, acc[XLEN-1:1]};
      end else begin
         trial = acc[2*XLEN-1:XLEN-1];
         diff  = trial - {1'b0, md};
         if (!diff[XLEN])
            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
      prod_fix  = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
      mul_res   = (fq[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      quot      = acc_nxt[XLEN-1:0];
      rem       = acc_nxt[2*XLEN-1:XLEN];
      div_res   = fq[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quot : quot);
      final_res = fq[2] ? div_res : mul_res;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (special || fast) ? DONE : CALC;
         CALC: begin
            if (flush)
               state_nxt = IDLE;
            else if (cnt == CW'(1))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         md     <= '0;
         fq     <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            fq   <= func3;
            sa_q <= sa;
            sb_q <= sb;
            cnt  <= CW'(XLEN);
            if (is_div) begin
               acc <= {{XLEN{1'b0}}, ma};
               md  <= mb;
            end else begin
               acc <= {{XLEN{1'b0}}, mb};
               md  <= ma;
            end
            if (special)
               result <= special_res;
            else if (fast)
               result <= fast_res;
         end else if ((state == CALC) && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
               result <= final_res;
         end
      end
   end

   assign busy      = (state == CALC);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule
